// File: rtl/seq_div16.sv
// seq_div16: iterative unsigned restoring divider.
// One quotient bit per clock, using a single WIDTH+1-bit subtract per step
// (A + ~B + 1, borrow taken from the inverted carry-out). Start/done
// handshake; results and the divide-by-zero flag hold until the next
// operation completes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready=1, waiting for start; operands captured on accept
// ST_RUN  | one restoring iteration per edge, counter 0..WIDTH-1;
//         | a zero divisor is resolved on the first RUN edge instead
// ST_DONE | done=1 for one cycle, results valid, back to IDLE

module seq_div16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    // The partial remainder is always below the divisor between steps, so
    // WIDTH bits hold it; the extra bit exists only in the shifted value.
    logic [WIDTH-1:0] rem_q,       rem_d;
    logic [WIDTH-1:0] shq_q,       shq_d;
    logic [WIDTH-1:0] dvs_q,       dvs_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q,       dbz_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] sub_sum;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] shq_next;

    // One restoring step: shift in the next dividend bit, trial-subtract.
    always_comb begin
        rem_shift = {rem_q, shq_q[WIDTH-1]};
        sub_sum   = {1'b0, rem_shift} + {1'b0, ~{1'b0, dvs_q}} + (WIDTH+2)'(1);
        // A successful subtract always leaves a value below the divisor, so
        // bit WIDTH of the difference is zero whenever carry-out is set.
        no_borrow = sub_sum[WIDTH+1] & ~sub_sum[WIDTH];
        rem_next  = no_borrow ? sub_sum[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        shq_next  = {shq_q[WIDTH-2:0], no_borrow};
    end

    // Next-state and datapath control; everything holds unless changed.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        shq_d       = shq_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shq_d   = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (dvs_q == '0) begin
                    // No iterations: the shift register still holds the dividend.
                    quotient_d  = '1;
                    remainder_d = shq_q;
                    dbz_d       = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_DONE;
                end else begin
                    rem_d = rem_next;
                    shq_d = shq_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        quotient_d  = shq_next;
                        remainder_d = rem_next;
                        dbz_d       = 1'b0;
                        cnt_d       = '0;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            shq_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            shq_q       <= shq_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // Handshake flags decode straight from the state register.
    always_comb begin
        ready       = (state_q == ST_IDLE);
        busy        = (state_q == ST_RUN);
        done        = (state_q == ST_DONE);
        quotient    = quotient_q;
        remainder   = remainder_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_seq_div16.sv
// Directed and bounded random bench for seq_div16.
module tb_seq_div16;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         ready, busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W-1:0] prev_q = '0;
    logic [W-1:0] prev_r = '0;
    logic         prev_z = 1'b0;

    seq_div16 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation and follow it to done; inputs scramble after accept.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ez, input int elat, input string tag);
        int n;
        int busy_n;
        @(negedge clk);
        check_val({tag, " ready"}, 32'(ready), 32'd1);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        n = 0;
        busy_n = 0;
        check_val({tag, " hold q"}, 32'(quotient), 32'(prev_q));
        check_val({tag, " hold r"}, 32'(remainder), 32'(prev_r));
        check_val({tag, " hold z"}, 32'(div_by_zero), 32'(prev_z));
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            n++;
        end
        check_val({tag, " latency"}, 32'(n), 32'(elat));
        check_val({tag, " busy cycles"}, 32'(busy_n), 32'(elat));
        check_val({tag, " quotient"}, 32'(quotient), 32'(eq));
        check_val({tag, " remainder"}, 32'(remainder), 32'(er));
        check_val({tag, " dbz"}, 32'(div_by_zero), 32'(ez));
        prev_q = eq;
        prev_r = er;
        prev_z = ez;
        @(negedge clk);
        check_val({tag, " done pulse"}, 32'(done), 32'd0);
        check_val({tag, " ready after"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int n;
        int cnt;
        int t1;
        int t2;
        logic [W-1:0] a;
        logic [W-1:0] b;

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_val("rst ready", 32'(ready), 32'd1);
        check_val("rst busy", 32'(busy), 32'd0);
        check_val("rst done", 32'(done), 32'd0);
        check_val("rst q", 32'(quotient), 32'd0);
        check_val("rst r", 32'(remainder), 32'd0);
        check_val("rst z", 32'(div_by_zero), 32'd0);

        // Basic and boundary divisions
        do_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16, "100/7");
        do_op(16'hFFFF, 16'h0001, 16'hFFFF, 16'd0, 1'b0, 16, "ffff/1");
        do_op(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 16, "ffff/ffff");
        do_op(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 16, "3/10");
        do_op(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1, "5/0");
        do_op(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 16, "9/3");

        // Starts during RUN and DONE are ignored
        @(negedge clk);
        dividend = 16'd200;
        divisor  = 16'd9;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        dividend = 16'd1000;
        divisor  = 16'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 5;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("ign latency", 32'(n), 32'd16);
        check_val("ign q", 32'(quotient), 32'd22);
        check_val("ign r", 32'(remainder), 32'd2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        repeat (25) begin
            if (done === 1'b1) cnt++;
            @(negedge clk);
        end
        check_val("ign extra done", 32'(cnt), 32'd0);
        check_val("ign q held", 32'(quotient), 32'd22);
        check_val("ign ready", 32'(ready), 32'd1);
        prev_q = 16'd22;
        prev_r = 16'd2;
        prev_z = 1'b0;

        // Back-to-back throughput with start held high
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        t1 = -1;
        t2 = -1;
        n = 0;
        while (t2 < 0 && n < 100) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) begin
                if (t1 < 0) t1 = cyc;
                else t2 = cyc;
            end
        end
        start = 1'b0;
        check_val("b2b period", 32'(t2 - t1), 32'(W + 2));
        check_val("b2b q", 32'(quotient), 32'd14);
        prev_q = 16'd14;
        prev_r = 16'd2;
        prev_z = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-RUN aborts without a done pulse
        dividend = 16'd50000;
        divisor  = 16'd123;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_val("abort ready", 32'(ready), 32'd1);
        check_val("abort busy", 32'(busy), 32'd0);
        check_val("abort done", 32'(done), 32'd0);
        check_val("abort q", 32'(quotient), 32'd0);
        check_val("abort r", 32'(remainder), 32'd0);
        check_val("abort z", 32'(div_by_zero), 32'd0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        check_val("abort no done", 32'(cnt), 32'd0);
        prev_q = '0;
        prev_r = '0;
        prev_z = 1'b0;
        do_op(16'd50000, 16'd123, 16'd406, 16'd62, 1'b0, 16, "50000/123");

        // Random regression against a behavioural reference
        for (int i = 0; i < 1500; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                default: b = W'($urandom);
            endcase
            if (b == '0) do_op(a, b, '1, a, 1'b1, 1, "rand dbz");
            else         do_op(a, b, a / b, a % b, 1'b0, 16, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
